// File: rtl/ysyx_24090010_mc_ctrl.sv
// ysyx_24090010_mc_ctrl: multi-cycle sequencer for the NPC core.
// Owns PC and instruction register, drives fetch and load/store handshakes,
// and emits one-cycle register-file / CSR writeback strobes.
// Optional bus watchdog: define YSYX_24090010_BUS_TIMEOUT_EN to enable it.
module ysyx_24090010_mc_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h80000000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  ins_type,
  input  logic        is_b_jump,
  input  logic [31:0] pc_jump,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rdata,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  output logic        lsu_wen,
  input  logic        lsu_rsp_valid,
  input  logic [31:0] lsu_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] mem_rdata,
  output logic        rf_wen,
  output logic        csr_wen,
  output logic        halt,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    EXEC       = 3'd2,
    MEM_REQ    = 3'd3,
    MEM_WAIT   = 3'd4,
    WB         = 3'd5,
    HALT       = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_mem_rdata;
  logic        r_bus_err;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_timeout;

  logic w_is_load, w_is_store, w_is_branch, w_is_jump;
  logic w_is_ecall, w_is_mret, w_is_csr, w_is_ebreak;

  // Instruction class decode from the datapath's ins_type
  always_comb begin
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jump   = 1'b0;
    w_is_ecall  = 1'b0;
    w_is_mret   = 1'b0;
    w_is_csr    = 1'b0;
    w_is_ebreak = 1'b0;
    case (ins_type)
      6'b000111, 6'b010010, 6'b011111, 6'b100000, 6'b100100: w_is_load = 1'b1;
      6'b000101, 6'b010000, 6'b010111:                       w_is_store = 1'b1;
      6'b001011, 6'b001100, 6'b011000,
      6'b011010, 6'b011100, 6'b011101:                       w_is_branch = 1'b1;
      6'b000010, 6'b000011:                                  w_is_jump = 1'b1;
      6'b100101:                                             w_is_ecall = 1'b1;
      6'b101000:                                             w_is_mret = 1'b1;
      6'b100110, 6'b100111:                                  w_is_csr = 1'b1;
      6'b111111:                                             w_is_ebreak = 1'b1;
      default: ;
    endcase
  end

  assign w_pc_plus4 = r_pc + 32'd4;

  // Redirect target selection applied on the writeback cycle
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_is_jump) begin
      w_pc_next = pc_jump;
    end else if (w_is_branch || w_is_ecall || w_is_mret) begin
      w_pc_next = is_b_jump ? pc_jump : w_pc_plus4;
    end
  end

`ifdef YSYX_24090010_BUS_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  // Counts cycles spent waiting for a bus response; zero outside wait states
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state == FETCH_WAIT || r_state == MEM_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  // Fires on the waiting cycle that brings the count up to the limit
  assign w_timeout = (({1'b0, r_wait_cnt} + 9'd1) == {1'b0, TIMEOUT_CYCLES});
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FETCH_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and Moore-style handshake / strobe outputs
  always_comb begin
    w_state_next  = r_state;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_wen       = 1'b0;
    rf_wen        = 1'b0;
    csr_wen       = 1'b0;
    halt          = 1'b0;
    case (r_state)
      FETCH_REQ: begin
        // Held low while reset is asserted so no request escapes during reset
        ifu_req_valid = ~reset;
        if (ifu_req_ready) w_state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (ifu_rsp_valid)  w_state_next = EXEC;
        else if (w_timeout) w_state_next = HALT;
      end
      EXEC: begin
        if (w_is_ebreak)                  w_state_next = HALT;
        else if (w_is_load || w_is_store) w_state_next = MEM_REQ;
        else                              w_state_next = WB;
      end
      MEM_REQ: begin
        lsu_req_valid = 1'b1;
        lsu_wen       = w_is_store;
        if (lsu_req_ready) w_state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (lsu_rsp_valid)  w_state_next = WB;
        else if (w_timeout) w_state_next = HALT;
      end
      WB: begin
        rf_wen       = ~(w_is_store | w_is_branch | w_is_ecall | w_is_mret);
        csr_wen      = w_is_csr | w_is_ecall;
        w_state_next = FETCH_REQ;
      end
      HALT: begin
        halt = 1'b1;
      end
      default: w_state_next = FETCH_REQ;
    endcase
  end

  // Architectural registers: PC, instruction, load data and sticky bus error
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_inst      <= 32'd0;
      r_mem_rdata <= 32'd0;
      r_bus_err   <= 1'b0;
    end else begin
      if (r_state == FETCH_WAIT && ifu_rsp_valid) begin
        r_inst <= ifu_rdata;
      end
      if (r_state == MEM_WAIT && lsu_rsp_valid && w_is_load) begin
        r_mem_rdata <= lsu_rdata;
      end
      if (r_state == WB) begin
        r_pc <= w_pc_next;
      end
      if ((r_state == FETCH_WAIT && !ifu_rsp_valid && w_timeout) ||
          (r_state == MEM_WAIT && !lsu_rsp_valid && w_timeout)) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign pc        = r_pc;
  assign ifu_addr  = r_pc;
  assign inst      = r_inst;
  assign mem_rdata = r_mem_rdata;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_ysyx_24090010_mc_ctrl.sv
// Directed bench for ysyx_24090010_mc_ctrl with a writeback scoreboard.
// Define YSYX_24090010_BUS_TIMEOUT_EN to exercise the watchdog path.
module tb_ysyx_24090010_mc_ctrl;

  localparam logic [31:0] RST_PC = 32'h80000000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  ins_type = 6'd0;
  logic        is_b_jump = 1'b0;
  logic [31:0] pc_jump = 32'd0;
  logic        ifu_req_valid;
  logic        ifu_req_ready = 1'b0;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rdata = 32'd0;
  logic        lsu_req_valid;
  logic        lsu_req_ready = 1'b0;
  logic        lsu_wen;
  logic        lsu_rsp_valid = 1'b0;
  logic [31:0] lsu_rdata = 32'd0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic        csr_wen;
  logic        halt;
  logic        bus_err;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc;

  typedef struct {
    logic        rf;
    logic        csr;
    logic [31:0] md;
    logic [31:0] npc;
  } exp_t;
  exp_t sb[$];

  ysyx_24090010_mc_ctrl #(
    .RESET_PC(RST_PC),
    .TIMEOUT_CYCLES(8'd4)
  ) dut (
    .clock(clock), .reset(reset), .ins_type(ins_type), .is_b_jump(is_b_jump),
    .pc_jump(pc_jump), .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .pc(pc), .inst(inst),
    .mem_rdata(mem_rdata), .rf_wen(rf_wen), .csr_wen(csr_wen), .halt(halt),
    .bus_err(bus_err)
  );

  always #5 clock = ~clock;

`define CHK(TAG, OBS, EXP) \
  begin \
    tests++; \
    assert ((OBS) === (EXP)) else begin \
      fails++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
    end \
  end

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete instruction with zero-wait fetch and configurable LSU delays
  task automatic run_instr(
    input string       name,
    input logic [5:0]  t,
    input logic [31:0] word,
    input logic        bj,
    input logic [31:0] pj,
    input bit          mem,
    input int          rdy_d,
    input int          rsp_d,
    input logic [31:0] ld,
    input logic        exp_wen,
    input logic        exp_rf,
    input logic        exp_csr,
    input logic [31:0] exp_md,
    input logic [31:0] exp_npc
  );
    exp_t e;
    int   c;
    int   held;
    int   exp_lat;
    c = 1;
    `CHK("fetch_valid", ifu_req_valid, 1'b1)
    `CHK("fetch_addr", ifu_addr, exp_pc)
    ifu_req_ready = 1'b1;
    tick(); c++;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rdata     = word;
    ins_type      = t;
    is_b_jump     = bj;
    pc_jump       = pj;
    e = '{rf: exp_rf, csr: exp_csr, md: exp_md, npc: exp_npc};
    sb.push_back(e);
    `CHK("fetch_wait_valid_low", ifu_req_valid, 1'b0)
    tick(); c++;
    ifu_rsp_valid = 1'b0;
    `CHK("inst_reg", inst, word)
    `CHK("exec_rf_wen", rf_wen, 1'b0)
    `CHK("exec_csr_wen", csr_wen, 1'b0)
    if (mem) begin
      tick(); c++;
      held = 0;
      for (int k = 0; k <= rdy_d; k++) begin
        if (lsu_req_valid === 1'b1) held++;
        `CHK("excl_valids", ifu_req_valid & lsu_req_valid, 1'b0)
        `CHK("lsu_wen", lsu_wen, exp_wen)
        lsu_req_ready = (k == rdy_d);
        tick(); c++;
      end
      lsu_req_ready = 1'b0;
      `CHK("lsu_valid_cycles", held, rdy_d + 1)
      for (int k = 0; k <= rsp_d; k++) begin
        `CHK("memwait_rf_wen", rf_wen, 1'b0)
        lsu_rsp_valid = (k == rsp_d);
        lsu_rdata     = (k == rsp_d) ? ld : 32'h0BAD0BAD;
        tick(); c++;
      end
      lsu_rsp_valid = 1'b0;
      exp_lat = 6 + rdy_d + rsp_d;
    end else begin
      tick(); c++;
      exp_lat = 4;
    end
    if (sb.size() == 0) begin
      `CHK("scoreboard_empty", sb.size(), 1)
    end else begin
      e = sb.pop_front();
      `CHK("wb_rf_wen", rf_wen, e.rf)
      `CHK("wb_csr_wen", csr_wen, e.csr)
      `CHK("wb_mem_rdata", mem_rdata, e.md)
      `CHK("wb_cycle", c, exp_lat)
      tick();
      `CHK("post_wb_rf_wen", rf_wen, 1'b0)
      `CHK("post_wb_pc", pc, e.npc)
      exp_pc = e.npc;
    end
    $display("[TB] %s type=%b pc->%h rf=%b csr=%b mem_rdata=%h", name, t, pc, rf_wen, csr_wen, mem_rdata);
  endtask

  initial begin
    int bad;
    // Reset state
    tick(); tick();
    `CHK("rst_ifu_valid", ifu_req_valid, 1'b0)
    `CHK("rst_pc", pc, RST_PC)
    `CHK("rst_inst", inst, 32'd0)
    `CHK("rst_mem_rdata", mem_rdata, 32'd0)
    `CHK("rst_lsu_valid", lsu_req_valid, 1'b0)
    `CHK("rst_rf_wen", rf_wen, 1'b0)
    `CHK("rst_csr_wen", csr_wen, 1'b0)
    `CHK("rst_halt", halt, 1'b0)
    `CHK("rst_bus_err", bus_err, 1'b0)
    reset = 1'b0;
    #1;
    exp_pc = RST_PC;
    $display("[TB] reset released pc=%h", pc);

    run_instr("alu",        6'b000000, 32'h00100093, 1'b0, 32'h0, 0, 0, 0, 32'h0,
              1'b0, 1'b1, 1'b0, 32'h0, 32'h80000004);
    run_instr("load_wait3", 6'b000111, 32'h0000A083, 1'b0, 32'h0, 1, 0, 3, 32'hDEADBEEF,
              1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h8000000C - 32'd4);
    run_instr("store_rdy2", 6'b000101, 32'h0010A023, 1'b0, 32'h0, 1, 2, 0, 32'h12345678,
              1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h8000000C);
    run_instr("br_taken",   6'b001011, 32'h00000063, 1'b1, 32'h80000100, 0, 0, 0, 32'h0,
              1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h80000100);
    run_instr("br_not",     6'b001011, 32'h00000063, 1'b0, 32'h80000200, 0, 0, 0, 32'h0,
              1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h80000104);
    run_instr("jump",       6'b000010, 32'h0000006F, 1'b0, 32'h80000200, 0, 0, 0, 32'h0,
              1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h80000200);
    run_instr("ecall",      6'b100101, 32'h00000073, 1'b1, 32'h80000300, 0, 0, 0, 32'h0,
              1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h80000300);
    run_instr("csr",        6'b100110, 32'h30029073, 1'b0, 32'h0, 0, 0, 0, 32'h0,
              1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h80000304);
    run_instr("mret",       6'b101000, 32'h30200073, 1'b1, 32'hFFFFFFFC, 0, 0, 0, 32'h0,
              1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hFFFFFFFC);
    run_instr("alu_wrap",   6'b000001, 32'h00000013, 1'b0, 32'h0, 0, 0, 0, 32'h0,
              1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h00000000);
    run_instr("load_zw",    6'b100100, 32'h00002083, 1'b0, 32'h0, 1, 0, 0, 32'hCAFEF00D,
              1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h00000004);

    // EBREAK: halt after EXEC and stay quiet
    `CHK("ebreak_fetch_valid", ifu_req_valid, 1'b1)
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rdata     = 32'h00100073;
    ins_type      = 6'b111111;
    tick();
    ifu_rsp_valid = 1'b0;
    `CHK("ebreak_exec_halt", halt, 1'b0)
    tick();
    `CHK("ebreak_halt", halt, 1'b1)
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      ifu_req_ready = 1'b1;
      lsu_req_ready = 1'b1;
      if (ifu_req_valid !== 1'b0 || lsu_req_valid !== 1'b0 || rf_wen !== 1'b0 ||
          csr_wen !== 1'b0 || halt !== 1'b1) bad++;
      tick();
    end
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    `CHK("halt_quiet_20", bad, 0)
    `CHK("halt_pc_hold", pc, 32'h00000004)
    $display("[TB] ebreak halt=%b pc=%h", halt, pc);

    reset = 1'b1;
    ifu_rsp_valid = 1'b1;
    tick();
    `CHK("rehalt_rst_pc", pc, RST_PC)
    `CHK("rehalt_rst_halt", halt, 1'b0)
    reset = 1'b0;
    #1;
    ifu_rsp_valid = 1'b0;
    exp_pc = RST_PC;
    $display("[TB] reset after halt pc=%h", pc);
    run_instr("alu_after_rst", 6'b000000, 32'h00100093, 1'b0, 32'h0, 0, 0, 0, 32'h0,
              1'b0, 1'b1, 1'b0, 32'h0, 32'h80000004);

    // Fetch with no response: watchdog or indefinite wait
    `CHK("to_fetch_valid", ifu_req_valid, 1'b1)
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
`ifdef YSYX_24090010_BUS_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      `CHK("to_wait_halt", halt, 1'b0)
      tick();
    end
    `CHK("to_halt", halt, 1'b1)
    `CHK("to_bus_err", bus_err, 1'b1)
    $display("[TB] timeout halt=%b bus_err=%b", halt, bus_err);
`else
    for (int k = 0; k < 100; k++) tick();
    `CHK("nto_valid", ifu_req_valid, 1'b0)
    `CHK("nto_halt", halt, 1'b0)
    `CHK("nto_bus_err", bus_err, 1'b0)
    ifu_rsp_valid = 1'b1;
    ifu_rdata     = 32'h00000013;
    ins_type      = 6'b000000;
    tick();
    ifu_rsp_valid = 1'b0;
    `CHK("nto_late_inst", inst, 32'h00000013)
    $display("[TB] no timeout after 100 cycles halt=%b bus_err=%b", halt, bus_err);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule
